// File: rtl/uart_pkg.sv
// Shared state encoding and frame-header helper for the UART transmit arbiter.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      PRESENT,
      DRAIN
   } state_t;

   localparam logic [3:0] HDR_TAG = 4'hA;

   // Header carries the tag in the upper nibble and the granted requester in the lower.
   function automatic logic [7:0] build_header(input logic [3:0] grant);
      return {HDR_TAG, grant};
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after last_grant (with wrap) that is asserting.
module rr_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned GW      = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [GW-1:0]      last_grant,
   output logic               grant_any,
   output logic [NUM_REQ-1:0] grant_oh,
   output logic [GW-1:0]      grant_idx
);

   logic [GW-1:0] cand;

   always_comb begin
      grant_any = 1'b0;
      grant_oh  = '0;
      grant_idx = '0;
      cand      = '0;
      // Offsets start at 1 so the previous grantee is searched last.
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         cand = GW'((32'(last_grant) + k) % NUM_REQ);
         if (!grant_any && req[cand]) begin
            grant_any = 1'b1;
            grant_idx = cand;
         end
      end
      if (grant_any) begin
         grant_oh[grant_idx] = 1'b1;
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ requesters; each granted word is sent as
// a frame of header, payload (LSB first) and optional XOR checksum.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int unsigned NUM_REQ     = 4,
   parameter int unsigned WORD_BYTES  = 4,
   parameter int unsigned CHECKSUM_EN = 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*WORD_BYTES*8-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ack,
   output logic [7:0]                    tx_data,
   output logic                          tx_data_ready,
   input  logic                          tx_ready_to_send,
   output logic                          busy,
   output logic                          frame_done
);

   localparam int unsigned WB        = WORD_BYTES * 8;
   localparam int unsigned CS_BYTES  = (CHECKSUM_EN != 0) ? 1 : 0;
   localparam int unsigned FRAME_LEN = 1 + WORD_BYTES + CS_BYTES;
   localparam int unsigned IDX_W     = $clog2(FRAME_LEN + 1);
   localparam int unsigned GW        = $clog2(NUM_REQ);

   state_t               state_q, state_d;
   logic [GW-1:0]        last_grant_q, last_grant_d;
   logic [WB-1:0]        word_q, word_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [7:0]           csum_q, csum_d;
   logic [7:0]           tx_data_q, tx_data_d;
   logic                 tx_data_ready_q, tx_data_ready_d;
   logic                 busy_q, busy_d;
   logic                 frame_done_q, frame_done_d;
   logic [NUM_REQ-1:0]   req_ack_q, req_ack_d;

   logic                 arb_any;
   logic [NUM_REQ-1:0]   arb_oh;
   logic [GW-1:0]        arb_idx;
   logic [WB-1:0]        word_sel;
   logic [7:0]           hdr;
   logic [7:0]           pay_byte;
   logic [7:0]           frame_byte;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .GW      (GW)
   ) u_rr_arbiter (
      .req        (req_valid),
      .last_grant (last_grant_q),
      .grant_any  (arb_any),
      .grant_oh   (arb_oh),
      .grant_idx  (arb_idx)
   );

   always_comb begin
      word_sel = '0;
      for (int unsigned r = 0; r < NUM_REQ; r++) begin
         if (arb_idx == GW'(r)) begin
            word_sel = req_data[r*WB +: WB];
         end
      end
   end

   always_comb begin
      hdr      = build_header(4'(last_grant_q));
      pay_byte = '0;
      for (int unsigned b = 0; b < WORD_BYTES; b++) begin
         if (idx_q == IDX_W'(b + 1)) begin
            pay_byte = word_q[b*8 +: 8];
         end
      end
      frame_byte = pay_byte;
      if (idx_q == '0) begin
         frame_byte = hdr;
      end else if (CHECKSUM_EN != 0 && idx_q == IDX_W'(WORD_BYTES + 1)) begin
         frame_byte = csum_q;
      end
   end

   // Grant, word capture and ack are taken together on the IDLE->LOAD edge, so the ack
   // pulse seen during LOAD already covers a latched word and the requester may move on.
   always_comb begin
      state_d         = state_q;
      last_grant_d    = last_grant_q;
      word_d          = word_q;
      idx_d           = idx_q;
      csum_d          = csum_q;
      tx_data_d       = tx_data_q;
      tx_data_ready_d = tx_data_ready_q;
      busy_d          = busy_q;
      frame_done_d    = 1'b0;
      req_ack_d       = '0;

      unique case (state_q)
         IDLE: begin
            if (arb_any && tx_ready_to_send) begin
               state_d      = LOAD;
               last_grant_d = arb_idx;
               word_d       = word_sel;
               req_ack_d    = arb_oh;
               busy_d       = 1'b1;
            end
         end
         LOAD: begin
            csum_d          = hdr;
            idx_d           = '0;
            tx_data_d       = hdr;
            tx_data_ready_d = 1'b1;
            state_d         = PRESENT;
         end
         PRESENT: begin
            // The sender drops ready only when it has taken the byte at its baud tick.
            if (!tx_ready_to_send) begin
               tx_data_ready_d = 1'b0;
               csum_d          = csum_q ^ pay_byte;
               idx_d           = idx_q + IDX_W'(1);
               state_d         = DRAIN;
            end
         end
         DRAIN: begin
            if (tx_ready_to_send) begin
               if (idx_q < IDX_W'(FRAME_LEN)) begin
                  tx_data_d       = frame_byte;
                  tx_data_ready_d = 1'b1;
                  state_d         = PRESENT;
               end else begin
                  tx_data_d    = '0;
                  frame_done_d = 1'b1;
                  busy_d       = 1'b0;
                  state_d      = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= IDLE;
         last_grant_q    <= GW'(NUM_REQ - 1);
         word_q          <= '0;
         idx_q           <= '0;
         csum_q          <= '0;
         tx_data_q       <= '0;
         tx_data_ready_q <= 1'b0;
         busy_q          <= 1'b0;
         frame_done_q    <= 1'b0;
         req_ack_q       <= '0;
      end else begin
         state_q         <= state_d;
         last_grant_q    <= last_grant_d;
         word_q          <= word_d;
         idx_q           <= idx_d;
         csum_q          <= csum_d;
         tx_data_q       <= tx_data_d;
         tx_data_ready_q <= tx_data_ready_d;
         busy_q          <= busy_d;
         frame_done_q    <= frame_done_d;
         req_ack_q       <= req_ack_d;
      end
   end

   always_comb begin
      req_ack       = req_ack_q;
      tx_data       = tx_data_q;
      tx_data_ready = tx_data_ready_q;
      busy          = busy_q;
      frame_done    = frame_done_q;
   end

endmodule
